regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regwb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/regwb_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
// Optional forwarding port is enabled with the REGWB_FWD_EN macro.
package regwb_pkg;

    localparam int REGWB_ADDR_W   = 5;
    localparam int REGWB_DATA_W   = 32;
    localparam int REGWB_NREQ_DEF = 3;

    // Width of an index able to name any of n requesters.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters with a last-grant pointer.
// Search starts one above the last granted index and wraps around.
module rr_arbiter
    import regwb_pkg::*;
#(
    parameter int NREQ = REGWB_NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant
);

    localparam int PW = ptr_w(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;

    // First valid requester above ptr wins; nothing granted in hold/reset.
    always_comb begin
        int idx;
        grant = '0;
        gidx  = ptr;
        idx   = 0;
        if (!rst && !hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (req_valid[idx] && grant == '0) begin
                    grant[idx] = 1'b1;
                    gidx       = PW'(idx);
                end
            end
        end
    end

    // Pointer moves to the winner on each transfer; reset favours req 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PW'(NREQ - 1);
        end else if (|grant) begin
            ptr <= gidx;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates write-back requesters onto a single register-file write port.
// Define REGWB_FWD_EN to add the fwd_rd_addr/fwd_hit/fwd_data bypass port.
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int NREQ   = REGWB_NREQ_DEF,
    parameter int ADDR_W = REGWB_ADDR_W,
    parameter int DATA_W = REGWB_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   write_en,
    output logic [ADDR_W-1:0]      data_addr,
    output logic [DATA_W-1:0]      data_in,
    output logic                   busy
`ifdef REGWB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]      fwd_rd_addr,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data
`endif
);

    logic [NREQ-1:0]   grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign busy      = write_en;

    // Grant is one-hot-or-zero, so an OR-mux picks the winner's payload.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register the transfer; writes to register 0 are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en  <= 1'b0;
            data_addr <= '0;
            data_in   <= '0;
        end else if (|grant) begin
            write_en  <= (sel_addr != '0);
            data_addr <= sel_addr;
            data_in   <= sel_data;
        end else begin
            write_en  <= 1'b0;
        end
    end

`ifdef REGWB_FWD_EN
    // Bypass the value being written this cycle to a same-cycle reader.
    always_comb begin
        fwd_hit  = write_en && (data_addr == fwd_rd_addr)
                   && (fwd_rd_addr != '0);
        fwd_data = data_in;
    end
`endif

endmodule
